// File: rtl/fifo_arbiter_pkg.sv
// Shared defaults and state encodings for the two-producer FIFO front end.
package fifo_ctrl_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int CNT_WIDTH_DEF  = 16;

    typedef enum logic {
        P_IDLE = 1'b0,
        P_PUSH = 1'b1
    } push_state_t;

    typedef enum logic {
        Q_IDLE = 1'b0,
        Q_POP  = 1'b1
    } pop_state_t;

endpackage

// File: rtl/fifo_arbiter_if.sv
// Producer, consumer and FIFO-side signals of the arbiter; master is the controller.
interface fifo_arbiter_if
    import fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
);

    logic                  req0;
    logic                  req1;
    logic [DATA_WIDTH-1:0] data0;
    logic [DATA_WIDTH-1:0] data1;
    logic                  ack0;
    logic                  ack1;
    logic                  pop_req;
    logic                  pop_valid;
    logic [DATA_WIDTH-1:0] pop_data;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic [DATA_WIDTH-1:0] fifo_wdata;
    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_WIDTH-1:0]  push_count;
    logic [CNT_WIDTH-1:0]  pop_count;

    modport master (
        input  req0, req1, data0, data1, pop_req, fifo_rdata, fifo_full, fifo_empty,
        output ack0, ack1, pop_valid, pop_data, fifo_push, fifo_pop, fifo_wdata,
               push_count, pop_count
    );

    modport slave (
        output req0, req1, data0, data1, pop_req, fifo_rdata, fifo_full, fifo_empty,
        input  ack0, ack1, pop_valid, pop_data, fifo_push, fifo_pop, fifo_wdata,
               push_count, pop_count
    );

endinterface

// File: rtl/fifo_arbiter_rr_arbiter2.sv
// Two-way round-robin selector; a masked requester cannot win this cycle.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic [1:0] mask,
    input  logic       last,
    output logic [1:0] grant
);

    logic [1:0] elig_s;

    // On a tie the requester that did not win last time is chosen.
    always_comb begin
        elig_s = req & ~mask;
        grant  = 2'b00;
        case (elig_s)
            2'b11: begin
                if (last) begin
                    grant = 2'b01;
                end else begin
                    grant = 2'b10;
                end
            end
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/fifo_arbiter.sv
// Arbitrates two producers into one FIFO and serves a single consumer; push and
// pop sides are independent two-state machines with registered outputs.
module fifo_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic          clk,
    input  logic          reset,
    fifo_arbiter_if.master bus
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    push_state_t           push_state_r;
    push_state_t           push_state_s;
    logic [1:0]            grant_s;
    logic [1:0]            ack_r;
    logic [1:0]            ack_s;
    logic                  push_r;
    logic                  push_s;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic [DATA_WIDTH-1:0] wdata_s;
    logic                  last_r;
    logic                  last_s;
    logic [CNT_WIDTH-1:0]  push_cnt_r;
    logic [CNT_WIDTH-1:0]  push_cnt_s;

    pop_state_t            pop_state_r;
    pop_state_t            pop_state_s;
    logic                  pop_r;
    logic                  pop_s;
    logic [DATA_WIDTH-1:0] pop_data_r;
    logic [DATA_WIDTH-1:0] pop_data_s;
    logic [CNT_WIDTH-1:0]  pop_cnt_r;
    logic [CNT_WIDTH-1:0]  pop_cnt_s;

    // The producer currently being acknowledged is masked so a slow req drop cannot re-win.
    rr_arbiter2 u_rr (
        .req   ({bus.req1, bus.req0}),
        .mask  (ack_r),
        .last  (last_r),
        .grant (grant_s)
    );

    // Push side next state: grant in P_IDLE, strobe for one cycle in P_PUSH.
    always_comb begin
        push_state_s = push_state_r;
        push_s       = 1'b0;
        ack_s        = 2'b00;
        wdata_s      = wdata_r;
        last_s       = last_r;
        push_cnt_s   = push_cnt_r;
        case (push_state_r)
            P_IDLE: begin
                if (!bus.fifo_full && (grant_s != 2'b00)) begin
                    push_state_s = P_PUSH;
                    push_s       = 1'b1;
                    ack_s        = grant_s;
                    last_s       = grant_s[1];
                    push_cnt_s   = push_cnt_r + CNT_ONE;
                    if (grant_s[1]) begin
                        wdata_s = bus.data1;
                    end else begin
                        wdata_s = bus.data0;
                    end
                end else begin
                    push_state_s = P_IDLE;
                end
            end
            P_PUSH: begin
                push_state_s = P_IDLE;
            end
            default: begin
                push_state_s = P_IDLE;
            end
        endcase
    end

    // Push side registers; reset returns the tie-break to favour requester 0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            push_state_r <= P_IDLE;
            push_r       <= 1'b0;
            ack_r        <= 2'b00;
            wdata_r      <= {DATA_WIDTH{1'b0}};
            last_r       <= 1'b1;
            push_cnt_r   <= {CNT_WIDTH{1'b0}};
        end else begin
            push_state_r <= push_state_s;
            push_r       <= push_s;
            ack_r        <= ack_s;
            wdata_r      <= wdata_s;
            last_r       <= last_s;
            push_cnt_r   <= push_cnt_s;
        end
    end

    // Pop side next state: capture the FIFO head, then strobe for one cycle.
    always_comb begin
        pop_state_s = pop_state_r;
        pop_s       = 1'b0;
        pop_data_s  = pop_data_r;
        pop_cnt_s   = pop_cnt_r;
        case (pop_state_r)
            Q_IDLE: begin
                if (bus.pop_req && !bus.fifo_empty) begin
                    pop_state_s = Q_POP;
                    pop_s       = 1'b1;
                    pop_data_s  = bus.fifo_rdata;
                    pop_cnt_s   = pop_cnt_r + CNT_ONE;
                end else begin
                    pop_state_s = Q_IDLE;
                end
            end
            Q_POP: begin
                pop_state_s = Q_IDLE;
            end
            default: begin
                pop_state_s = Q_IDLE;
            end
        endcase
    end

    // Pop side registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pop_state_r <= Q_IDLE;
            pop_r       <= 1'b0;
            pop_data_r  <= {DATA_WIDTH{1'b0}};
            pop_cnt_r   <= {CNT_WIDTH{1'b0}};
        end else begin
            pop_state_r <= pop_state_s;
            pop_r       <= pop_s;
            pop_data_r  <= pop_data_s;
            pop_cnt_r   <= pop_cnt_s;
        end
    end

    assign bus.fifo_push  = push_r;
    assign bus.ack0       = ack_r[0];
    assign bus.ack1       = ack_r[1];
    assign bus.fifo_wdata = wdata_r;
    assign bus.push_count = push_cnt_r;
    assign bus.fifo_pop   = pop_r;
    assign bus.pop_valid  = pop_r;
    assign bus.pop_data   = pop_data_r;
    assign bus.pop_count  = pop_cnt_r;

endmodule

// File: tb/tb_fifo_arbiter.sv
// Directed scenarios plus randomized traffic against a queue-backed FIFO and a rule-level model.
module tb_fifo_arbiter;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    fifo_arbiter_if #(.DATA_WIDTH(8), .CNT_WIDTH(16)) bus ();
    fifo_arbiter_if #(.DATA_WIDTH(8), .CNT_WIDTH(4))  wbus ();

    fifo_arbiter #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    fifo_arbiter #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut_wrap (
        .clk   (clk),
        .reset (reset),
        .bus   (wbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // {fifo_push, ack1, ack0, fifo_pop, pop_valid}
    function automatic logic [4:0] strobes();
        return {bus.fifo_push, bus.ack1, bus.ack0, bus.fifo_pop, bus.pop_valid};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic init_inputs();
        bus.req0 = 1'b0;       bus.req1 = 1'b0;
        bus.data0 = 8'h00;     bus.data1 = 8'h00;
        bus.pop_req = 1'b0;    bus.fifo_rdata = 8'h00;
        bus.fifo_full = 1'b0;  bus.fifo_empty = 1'b1;
        wbus.req0 = 1'b0;      wbus.req1 = 1'b0;
        wbus.data0 = 8'h00;    wbus.data1 = 8'h00;
        wbus.pop_req = 1'b0;   wbus.fifo_rdata = 8'h00;
        wbus.fifo_full = 1'b0; wbus.fifo_empty = 1'b1;
    endtask

    task automatic do_reset();
        init_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        init_inputs();
        bus.req0 = 1'b1; bus.data0 = 8'hFF; bus.pop_req = 1'b1;
        bus.fifo_empty = 1'b0; bus.fifo_rdata = 8'hEE;
        reset = 1'b0;
        tick();
        tick();
        n_tests++;
        if ({strobes(), bus.fifo_wdata, bus.pop_data, bus.push_count, bus.pop_count} !== 53'd0) begin
            n_fail++;
            $display("FAIL reset_state: strobes=%b wdata=%h pdata=%h pc=%0d qc=%0d, want all 0",
                     strobes(), bus.fifo_wdata, bus.pop_data, bus.push_count, bus.pop_count);
        end
        init_inputs();
        reset = 1'b1;
    endtask

    task automatic test_single_push();
        do_reset();
        bus.req0 = 1'b1; bus.data0 = 8'hA5;
        tick();
        n_tests++;
        if (strobes() !== 5'b10100 || bus.fifo_wdata !== 8'hA5 || bus.push_count !== 16'd1) begin
            n_fail++;
            $display("FAIL single_push: strobes=%b wdata=%h pc=%0d, want 10100 a5 1",
                     strobes(), bus.fifo_wdata, bus.push_count);
        end
        tick();
        bus.req0 = 1'b0;
        n_tests++;
        if (strobes() !== 5'b00000) begin
            n_fail++;
            $display("FAIL single_push_one_cycle: strobes=%b want 00000", strobes());
        end
        tick();
        n_tests++;
        if (strobes() !== 5'b00000 || bus.push_count !== 16'd1) begin
            n_fail++;
            $display("FAIL single_push_no_repeat: strobes=%b pc=%0d want 00000 1", strobes(), bus.push_count);
        end
    endtask

    task automatic test_round_robin();
        logic [4:0] exp_s;
        logic [7:0] exp_d;
        do_reset();
        bus.req0 = 1'b1; bus.data0 = 8'h11;
        bus.req1 = 1'b1; bus.data1 = 8'h22;
        for (int i = 0; i < 8; i++) begin
            tick();
            exp_s = 5'b00000;
            exp_d = bus.fifo_wdata;
            if (i % 2 == 0) begin
                exp_s = (i % 4 == 0) ? 5'b10100 : 5'b11000;
                exp_d = (i % 4 == 0) ? 8'h11 : 8'h22;
            end
            n_tests++;
            if (strobes() !== exp_s || bus.fifo_wdata !== exp_d) begin
                n_fail++;
                $display("FAIL round_robin[%0d]: strobes=%b wdata=%h, want %b %h",
                         i, strobes(), bus.fifo_wdata, exp_s, exp_d);
            end
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        tick();
    endtask

    task automatic test_full_stall();
        do_reset();
        bus.fifo_full = 1'b1;
        bus.req1 = 1'b1; bus.data1 = 8'hC3;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if (strobes() !== 5'b00000 || bus.push_count !== 16'd0) begin
                n_fail++;
                $display("FAIL full_stall[%0d]: strobes=%b pc=%0d want 00000 0", i, strobes(), bus.push_count);
            end
        end
        bus.fifo_full = 1'b0;
        tick();
        n_tests++;
        if (strobes() !== 5'b11000 || bus.fifo_wdata !== 8'hC3) begin
            n_fail++;
            $display("FAIL full_release: strobes=%b wdata=%h want 11000 c3", strobes(), bus.fifo_wdata);
        end
        tick();
        bus.req1 = 1'b0;
        // Pointer left at requester 1 after its win, so 0 takes the next tie.
        bus.req0 = 1'b1; bus.data0 = 8'h0D; bus.req1 = 1'b1; bus.data1 = 8'h1D;
        tick();
        n_tests++;
        if (strobes() !== 5'b10100 || bus.fifo_wdata !== 8'h0D) begin
            n_fail++;
            $display("FAIL full_tie_after: strobes=%b wdata=%h want 10100 0d", strobes(), bus.fifo_wdata);
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        tick();
    endtask

    task automatic test_pop();
        do_reset();
        bus.fifo_empty = 1'b0; bus.fifo_rdata = 8'h3C; bus.pop_req = 1'b1;
        tick();
        n_tests++;
        if (strobes() !== 5'b00011 || bus.pop_data !== 8'h3C || bus.pop_count !== 16'd1) begin
            n_fail++;
            $display("FAIL pop_basic: strobes=%b pdata=%h qc=%0d want 00011 3c 1",
                     strobes(), bus.pop_data, bus.pop_count);
        end
        bus.fifo_empty = 1'b1; bus.fifo_rdata = 8'h00;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if (strobes() !== 5'b00000 || bus.pop_data !== 8'h3C || bus.pop_count !== 16'd1) begin
                n_fail++;
                $display("FAIL pop_empty_wait[%0d]: strobes=%b pdata=%h qc=%0d want 00000 3c 1",
                         i, strobes(), bus.pop_data, bus.pop_count);
            end
        end
        bus.pop_req = 1'b0;
    endtask

    task automatic test_same_cycle_and_abort();
        do_reset();
        bus.req0 = 1'b1; bus.data0 = 8'h5A;
        bus.pop_req = 1'b1; bus.fifo_empty = 1'b0; bus.fifo_rdata = 8'h77;
        tick();
        n_tests++;
        if (strobes() !== 5'b10111 || bus.fifo_wdata !== 8'h5A || bus.pop_data !== 8'h77) begin
            n_fail++;
            $display("FAIL push_pop_same: strobes=%b wdata=%h pdata=%h want 10111 5a 77",
                     strobes(), bus.fifo_wdata, bus.pop_data);
        end
        reset = 1'b0;
        tick();
        n_tests++;
        if ({strobes(), bus.fifo_wdata, bus.pop_data, bus.push_count, bus.pop_count} !== 53'd0) begin
            n_fail++;
            $display("FAIL reset_abort: strobes=%b wdata=%h pdata=%h pc=%0d qc=%0d, want all 0",
                     strobes(), bus.fifo_wdata, bus.pop_data, bus.push_count, bus.pop_count);
        end
        init_inputs();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_counter_wrap();
        do_reset();
        for (int i = 0; i < 17; i++) begin
            wbus.req0 = 1'b1;
            wbus.data0 = 8'(i);
            tick();
            wbus.req0 = 1'b0;
            tick();
            if (i == 15) begin
                n_tests++;
                if (wbus.push_count !== 4'd0) begin
                    n_fail++;
                    $display("FAIL wrap_16: push_count=%0d want 0", wbus.push_count);
                end
            end
        end
        n_tests++;
        if (wbus.push_count !== 4'd1) begin
            n_fail++;
            $display("FAIL wrap_17: push_count=%0d want 1", wbus.push_count);
        end
    endtask

    task automatic test_random();
        logic [7:0]  q[$];
        logic        e_push, e_pop, e_last, n_push, n_pop, win1;
        logic [1:0]  e_ack, n_ack;
        logic [7:0]  e_wdata, e_pdata;
        logic [15:0] e_pc, e_qc;
        logic        p_push, p_pop;
        logic [7:0]  p_wdata;
        logic        done0, done1, donep, elig0, elig1;
        do_reset();
        e_push = 1'b0; e_pop = 1'b0; e_last = 1'b1; e_ack = 2'b00;
        e_wdata = 8'h00; e_pdata = 8'h00; e_pc = 16'd0; e_qc = 16'd0;
        done0 = 1'b0; done1 = 1'b0; donep = 1'b0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            // Expected outputs of the next cycle from the inputs seen in this one.
            elig0  = bus.req0 && !e_ack[0];
            elig1  = bus.req1 && !e_ack[1];
            n_push = !e_push && !bus.fifo_full && (elig0 || elig1);
            n_ack  = 2'b00;
            p_push = e_push; p_pop = e_pop; p_wdata = e_wdata;
            if (n_push) begin
                win1    = elig1 && (!elig0 || !e_last);
                n_ack   = win1 ? 2'b10 : 2'b01;
                e_wdata = win1 ? bus.data1 : bus.data0;
                e_last  = win1;
                e_pc    = e_pc + 16'd1;
            end
            n_pop = !e_pop && bus.pop_req && !bus.fifo_empty;
            if (n_pop) begin
                e_pdata = bus.fifo_rdata;
                e_qc    = e_qc + 16'd1;
            end
            e_push = n_push; e_ack = n_ack; e_pop = n_pop;

            tick();
            n_tests++;
            if (strobes() !== {e_push, e_ack, e_pop, e_pop}) begin
                n_fail++;
                $display("FAIL rand_strobes@%0d: got %b want %b", cyc, strobes(), {e_push, e_ack, e_pop, e_pop});
            end
            n_tests++;
            if (bus.fifo_wdata !== e_wdata || bus.pop_data !== e_pdata) begin
                n_fail++;
                $display("FAIL rand_data@%0d: wdata=%h pdata=%h want %h %h",
                         cyc, bus.fifo_wdata, bus.pop_data, e_wdata, e_pdata);
            end
            n_tests++;
            if (bus.push_count !== e_pc || bus.pop_count !== e_qc) begin
                n_fail++;
                $display("FAIL rand_counts@%0d: pc=%0d qc=%0d want %0d %0d",
                         cyc, bus.push_count, bus.pop_count, e_pc, e_qc);
            end

            // FIFO storage reacts at the edge that ended the strobe cycle.
            if (p_pop && q.size() > 0) void'(q.pop_front());
            if (p_push) q.push_back(p_wdata);
            bus.fifo_full  = (q.size() >= 4);
            bus.fifo_empty = (q.size() == 0);
            bus.fifo_rdata = (q.size() > 0) ? q[0] : 8'h00;

            if (e_ack[0]) done0 = 1'b1;
            else if (done0) begin bus.req0 = 1'b0; done0 = 1'b0; end
            else if (!bus.req0 && $urandom_range(0, 2) == 0) begin
                bus.req0 = 1'b1; bus.data0 = 8'($urandom);
            end
            if (e_ack[1]) done1 = 1'b1;
            else if (done1) begin bus.req1 = 1'b0; done1 = 1'b0; end
            else if (!bus.req1 && $urandom_range(0, 2) == 0) begin
                bus.req1 = 1'b1; bus.data1 = 8'($urandom);
            end
            if (e_pop) donep = 1'b1;
            else if (donep) begin bus.pop_req = 1'b0; donep = 1'b0; end
            else if (!bus.pop_req && $urandom_range(0, 3) == 0) bus.pop_req = 1'b1;
        end
        init_inputs();
        tick();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        init_inputs();
        test_reset();
        test_single_push();
        test_round_robin();
        test_full_stall();
        test_pop();
        test_same_cycle_and_abort();
        test_counter_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
